// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: serial MSB-first config shifter with single-cycle commit to the LUT16to1 array.
// Optional trailing even-parity bit check when LUT_CFG_PARITY_EN is defined.
`timescale 1ns/1ps
module lut_cfg_loader #(
  parameter int LUT_COUNT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic                      cfg_valid,
  input  logic                      cfg_bit,
  output logic                      cfg_ready,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_err,
  output logic [16*LUT_COUNT-1:0]   lut_cfg
);
  localparam int N = 16*LUT_COUNT;
  localparam int CNT_W = $clog2(N);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, COMMIT} state_t;
`ifdef LUT_CFG_PARITY_EN
  localparam state_t AFTER_LAST = PARITY;
`else
  localparam state_t AFTER_LAST = COMMIT;
`endif
  state_t state, state_n;
  logic [N-1:0] shadow, shadow_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic take, last, restart;
  assign take = cfg_valid && cfg_ready;
  assign last = cnt == CNT_W'(N-1);
  assign restart = cfg_start && state != COMMIT;
  always_comb begin
    state_n = state;
    shadow_n = shadow;
    cnt_n = cnt;
    if (restart) begin
      state_n = SHIFT;
      shadow_n = '0;
      cnt_n = '0;
    end else if (take && state == SHIFT) begin
      shadow_n = {shadow[N-2:0], cfg_bit};
      cnt_n = last ? cnt : cnt + 1'b1;
      state_n = last ? AFTER_LAST : SHIFT;
    end else if (take && state == PARITY) begin
      state_n = (cfg_bit == ^shadow) ? COMMIT : IDLE;
    end else if (state == COMMIT) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shadow <= '0;
      cnt <= '0;
      lut_cfg <= '0;
      cfg_ready <= 1'b0;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      state <= state_n;
      shadow <= shadow_n;
      cnt <= cnt_n;
      cfg_ready <= state_n == SHIFT || state_n == PARITY;
      cfg_busy <= state_n != IDLE;
      cfg_done <= state == COMMIT;
      if (state == COMMIT) lut_cfg <= shadow;
    end
  end
`ifdef LUT_CFG_PARITY_EN
  logic err_set;
  assign err_set = take && state == PARITY && !cfg_start && cfg_bit != ^shadow;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else if (restart) cfg_err <= 1'b0;
    else if (err_set) cfg_err <= 1'b1;
  end
`else
  assign cfg_err = 1'b0;
`endif
endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: directed bench for lut_cfg_loader with a commit scoreboard.
`timescale 1ns/1ps
module tb_lut_cfg_loader;
  logic clk = 0, rst_n = 0, cfg_start = 0, cfg_valid = 0, cfg_bit = 0;
  logic cfg_ready, cfg_busy, cfg_done, cfg_err;
  logic [63:0] lut_cfg;
  logic [63:0] q[$];
  int total = 0, bad = 0, done_cnt = 0, rdy_low = 0;

  lut_cfg_loader #(.LUT_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_ready(cfg_ready), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .lut_cfg(lut_cfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cfg_done) begin
      done_cnt++;
      if (q.size() == 0) chk("unexpected_done", lut_cfg, 64'hx);
      else chk("commit", lut_cfg, q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    cfg_start = 1;
    tick();
    cfg_start = 0;
  endtask

  task automatic send(input logic [63:0] d, input int gap, input bit flip);
    for (int i = 63; i >= 0; i--) begin
      if (gap != 0) begin
        cfg_valid = 0;
        if (!cfg_ready) rdy_low++;
        tick();
      end
      cfg_valid = 1;
      cfg_bit = d[i];
      if (!cfg_ready) rdy_low++;
      tick();
    end
`ifdef LUT_CFG_PARITY_EN
    cfg_valid = 1;
    cfg_bit = (^d) ^ flip;
    tick();
`else
    if (flip) $display("note: parity flip ignored without parity build");
`endif
    cfg_valid = 0;
  endtask

  initial begin
    logic [15:0] f00d;
    int d0;
    f00d = 16'hF00D;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    tick();
    chk("rst_lut", lut_cfg, 64'h0);
    chk("rst_ready", 64'(cfg_ready), 64'h0);
    chk("rst_busy", 64'(cfg_busy), 64'h0);
    chk("rst_done", 64'(cfg_done), 64'h0);
    chk("rst_err", 64'(cfg_err), 64'h0);

    // full load with continuous valid, exact commit timing
    q.push_back(64'hDEADBEEFCAFEF00D);
    start();
    chk("start_busy", 64'(cfg_busy), 64'h1);
    chk("start_ready", 64'(cfg_ready), 64'h1);
    send(64'hDEADBEEFCAFEF00D, 0, 0);
    chk("pre_commit_done", 64'(cfg_done), 64'h0);
    chk("pre_commit_lut", lut_cfg, 64'h0);
    chk("pre_commit_ready", 64'(cfg_ready), 64'h0);
    tick();
    chk("done_pulse", 64'(cfg_done), 64'h1);
    chk("lut_after_commit", lut_cfg, 64'hDEADBEEFCAFEF00D);
    tick();
    chk("done_one_cycle", 64'(cfg_done), 64'h0);
    chk("busy_idle", 64'(cfg_busy), 64'h0);
    for (int s = 0; s < 16; s++) chk($sformatf("lut0_sel%0d", s), 64'(lut_cfg[s]), 64'(f00d[s]));

    // asynchronous reset mid-cycle during SHIFT
    start();
    cfg_valid = 1;
    cfg_bit = 1;
    repeat (10) tick();
    cfg_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("async_lut", lut_cfg, 64'h0);
    chk("async_busy", 64'(cfg_busy), 64'h0);
    chk("async_ready", 64'(cfg_ready), 64'h0);
    chk("async_done", 64'(cfg_done), 64'h0);
    #2 rst_n = 1;
    tick();

    // valid toggling every cycle
    q.push_back(64'hDEADBEEFCAFEF00D);
    d0 = done_cnt;
    rdy_low = 0;
    start();
    send(64'hDEADBEEFCAFEF00D, 1, 0);
    repeat (3) tick();
    chk("gap_ready_held", 64'(rdy_low), 64'h0);
    chk("gap_single_done", 64'(done_cnt - d0), 64'h1);
    chk("gap_lut", lut_cfg, 64'hDEADBEEFCAFEF00D);

    // restart mid-load; valid during start cycles must be dropped
    cfg_valid = 1;
    cfg_bit = 1;
    start();
    for (int i = 0; i < 20; i++) begin
      cfg_bit = 1'($urandom);
      tick();
    end
    cfg_bit = 1;
    start();
    chk("restart_lut_kept", lut_cfg, 64'hDEADBEEFCAFEF00D);
    q.push_back(64'h0123456789ABCDEF);
    send(64'h0123456789ABCDEF, 0, 0);
    chk("restart_pre_commit", lut_cfg, 64'hDEADBEEFCAFEF00D);
    tick();
    chk("restart_done", 64'(cfg_done), 64'h1);
    tick();

`ifdef LUT_CFG_PARITY_EN
    d0 = done_cnt;
    start();
    send(64'hFFFF0000FFFF0001, 0, 1);
    repeat (2) tick();
    chk("par_err", 64'(cfg_err), 64'h1);
    chk("par_no_done", 64'(done_cnt - d0), 64'h0);
    chk("par_lut_kept", lut_cfg, 64'h0123456789ABCDEF);
    start();
    chk("par_err_clr", 64'(cfg_err), 64'h0);
    q.push_back(64'hA5A5A5A5A5A5A5A4);
    send(64'hA5A5A5A5A5A5A5A4, 0, 0);
    repeat (2) tick();
    chk("par_good_err", 64'(cfg_err), 64'h0);
    chk("par_good_done", 64'(done_cnt - d0), 64'h1);
`else
    chk("err_tied_low", 64'(cfg_err), 64'h0);
`endif

    // reset after 30 bits, then full load with start held across commit
    start();
    cfg_valid = 1;
    cfg_bit = 1;
    repeat (30) tick();
    cfg_valid = 0;
    rst_n = 0;
    #1;
    chk("rst30_lut", lut_cfg, 64'h0);
    chk("rst30_busy", 64'(cfg_busy), 64'h0);
    #2 rst_n = 1;
    tick();
    q.push_back(64'hFFFF0000FFFF0000);
    start();
    send(64'hFFFF0000FFFF0000, 0, 0);
    cfg_start = 1;
    tick();
    chk("commit_ignores_start", 64'(cfg_busy), 64'h0);
    chk("final_done", 64'(cfg_done), 64'h1);
    chk("final_lut", lut_cfg, 64'hFFFF0000FFFF0000);
    tick();
    cfg_start = 0;
    chk("start_while_done_busy", 64'(cfg_busy), 64'h1);
    chk("start_while_done_ready", 64'(cfg_ready), 64'h1);
    tick();
    chk("scoreboard_empty", 64'(q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
